// File: rtl/wb_prj_mux_if.sv
// Upstream Wishbone slave port shared by the multi-project host block and its master.
interface wb_prj_mux_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/wb_prj_mux.sv
// Multi-project host: CSR-selected Wishbone forwarding with timeout, guarded IO mux
// and masked/sticky IRQ aggregation for N_PRJ user macros.
module wb_prj_mux #(
   parameter int unsigned N_PRJ       = 4,
   parameter int unsigned IO_W        = 17,
   parameter logic [31:0] CSR_BASE    = 32'h3000_0000,
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   wb_prj_mux_if.slave             wbs,
   output logic [N_PRJ-1:0]        prj_cyc_o,
   output logic [N_PRJ-1:0]        prj_stb_o,
   output logic                    prj_we_o,
   output logic [3:0]              prj_sel_o,
   output logic [31:0]             prj_adr_o,
   output logic [31:0]             prj_dat_o,
   input  logic [N_PRJ-1:0]        prj_ack_i,
   input  logic [32*N_PRJ-1:0]     prj_dat_i,
   input  logic [IO_W*N_PRJ-1:0]   prj_io_out_i,
   input  logic [IO_W*N_PRJ-1:0]   prj_io_oeb_i,
   output logic [IO_W-1:0]         io_out,
   output logic [IO_W-1:0]         io_oeb,
   input  logic [3*N_PRJ-1:0]      prj_irq_i,
   output logic [2:0]              user_irq
);
   localparam int unsigned MAX_PRJ = 8;
   localparam int unsigned SEL_W   = 3;
   localparam int unsigned TMR_W   = 16;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CSR  = 2'd1;
   localparam logic [1:0] ST_FWD  = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   localparam logic [5:0] OFS_SEL  = 6'h0;
   localparam logic [5:0] OFS_MASK = 6'h1;
   localparam logic [5:0] OFS_PEND = 6'h2;
   localparam logic [5:0] OFS_STAT = 6'h3;

   logic [1:0]        state_q, state_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [2:0]        mask_q, mask_d;
   logic [2:0]        pend_q, pend_d;
   logic              tflag_q, tflag_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic              ack_q, ack_d;
   logic [31:0]       rdat_q, rdat_d;
   logic [N_PRJ-1:0]  cyc_q, cyc_d;
   logic              we_q, we_d;
   logic [3:0]        bsel_q, bsel_d;
   logic [31:0]       adr_q, adr_d;
   logic [31:0]       wdat_q, wdat_d;
   logic [IO_W-1:0]   io_out_q, io_out_d;
   logic [IO_W-1:0]   io_oeb_q, io_oeb_d;
   logic              guard_q, guard_d;
   logic [2:0]        user_irq_q, user_irq_d;

   // Per-project views padded to 8 entries so a 3-bit select indexes them exactly.
   logic [31:0]        dat_arr [MAX_PRJ];
   logic [IO_W-1:0]    out_arr [MAX_PRJ];
   logic [IO_W-1:0]    oeb_arr [MAX_PRJ];
   logic [2:0]         irq_arr [MAX_PRJ];
   logic [MAX_PRJ-1:0] ack_ext;
   logic [MAX_PRJ-1:0] onehot;

   for (genvar k = 0; k < MAX_PRJ; k++) begin : g_pad
      if (k < N_PRJ) begin : g_on
         assign dat_arr[k] = prj_dat_i[32*k +: 32];
         assign out_arr[k] = prj_io_out_i[IO_W*k +: IO_W];
         assign oeb_arr[k] = prj_io_oeb_i[IO_W*k +: IO_W];
         assign irq_arr[k] = prj_irq_i[3*k +: 3];
      end else begin : g_off
         assign dat_arr[k] = '0;
         assign out_arr[k] = '0;
         assign oeb_arr[k] = '1;
         assign irq_arr[k] = '0;
      end
   end

   assign ack_ext = MAX_PRJ'(prj_ack_i);
   assign onehot  = MAX_PRJ'(1) << sel_q;

   logic       req;
   logic       csr_hit;
   logic [5:0] ofs;

   assign req     = wbs.wbs_cyc_i & wbs.wbs_stb_i;
   assign csr_hit = (wbs.wbs_adr_i[31:8] == CSR_BASE[31:8]);
   assign ofs     = wbs.wbs_adr_i[7:2];

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      mask_d     = mask_q;
      pend_d     = pend_q | irq_arr[sel_q];
      tflag_d    = tflag_q;
      timer_d    = timer_q;
      ack_d      = 1'b0;
      rdat_d     = '0;
      cyc_d      = cyc_q;
      we_d       = we_q;
      bsel_d     = bsel_q;
      adr_d      = adr_q;
      wdat_d     = wdat_q;
      guard_d    = 1'b0;
      io_out_d   = guard_q ? '0 : out_arr[sel_q];
      io_oeb_d   = guard_q ? '1 : oeb_arr[sel_q];
      user_irq_d = pend_q & mask_q;

      case (state_q)
         ST_IDLE: begin
            if (req && csr_hit) begin
               // CSR access completes on this edge so ack follows stb by one cycle.
               state_d = ST_CSR;
               ack_d   = 1'b1;
               case (ofs)
                  OFS_SEL: begin
                     rdat_d = 32'(sel_q);
                     if (wbs.wbs_we_i && (wbs.wbs_dat_i < 32'(N_PRJ))) begin
                        sel_d   = wbs.wbs_dat_i[SEL_W-1:0];
                        guard_d = (wbs.wbs_dat_i[SEL_W-1:0] != sel_q);
                     end
                  end
                  OFS_MASK: begin
                     rdat_d = 32'(mask_q);
                     if (wbs.wbs_we_i) mask_d = wbs.wbs_dat_i[2:0];
                  end
                  OFS_PEND: begin
                     rdat_d = 32'(pend_q);
                     if (wbs.wbs_we_i) pend_d = (pend_q & ~wbs.wbs_dat_i[2:0]) | irq_arr[sel_q];
                  end
                  OFS_STAT: begin
                     rdat_d = {16'h0, 8'(N_PRJ), 7'h0, tflag_q};
                     if (!wbs.wbs_we_i) tflag_d = 1'b0;
                  end
                  default: rdat_d = '0;
               endcase
            end else if (req) begin
               state_d = ST_FWD;
               cyc_d   = onehot[N_PRJ-1:0];
               we_d    = wbs.wbs_we_i;
               bsel_d  = wbs.wbs_sel_i;
               adr_d   = wbs.wbs_adr_i;
               wdat_d  = wbs.wbs_dat_i;
               timer_d = '0;
            end
         end
         ST_CSR: state_d = ST_IDLE;
         ST_FWD: begin
            if (!wbs.wbs_cyc_i) begin
               state_d = ST_IDLE;
               cyc_d   = '0;
            end else if (ack_ext[sel_q]) begin
               state_d = ST_RESP;
               cyc_d   = '0;
               ack_d   = 1'b1;
               rdat_d  = dat_arr[sel_q];
            end else if (timer_q == TMR_W'(TIMEOUT_CYC)) begin
               state_d = ST_RESP;
               cyc_d   = '0;
               ack_d   = 1'b1;
               rdat_d  = ERR_DATA;
               tflag_d = 1'b1;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q    <= ST_IDLE;
         sel_q      <= '0;
         mask_q     <= '0;
         pend_q     <= '0;
         tflag_q    <= 1'b0;
         timer_q    <= '0;
         ack_q      <= 1'b0;
         rdat_q     <= '0;
         cyc_q      <= '0;
         we_q       <= 1'b0;
         bsel_q     <= '0;
         adr_q      <= '0;
         wdat_q     <= '0;
         io_out_q   <= '0;
         io_oeb_q   <= '1;
         guard_q    <= 1'b0;
         user_irq_q <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         mask_q     <= mask_d;
         pend_q     <= pend_d;
         tflag_q    <= tflag_d;
         timer_q    <= timer_d;
         ack_q      <= ack_d;
         rdat_q     <= rdat_d;
         cyc_q      <= cyc_d;
         we_q       <= we_d;
         bsel_q     <= bsel_d;
         adr_q      <= adr_d;
         wdat_q     <= wdat_d;
         io_out_q   <= io_out_d;
         io_oeb_q   <= io_oeb_d;
         guard_q    <= guard_d;
         user_irq_q <= user_irq_d;
      end
   end

   assign wbs.wbs_ack_o = ack_q;
   assign wbs.wbs_dat_o = rdat_q;
   assign prj_cyc_o     = cyc_q;
   assign prj_stb_o     = cyc_q;
   assign prj_we_o      = we_q;
   assign prj_sel_o     = bsel_q;
   assign prj_adr_o     = adr_q;
   assign prj_dat_o     = wdat_q;
   assign io_out        = io_out_q;
   assign io_oeb        = io_oeb_q;
   assign user_irq      = user_irq_q;
endmodule

// File: tb/tb_wb_prj_mux.sv
// Bench for wb_prj_mux: vector table of Wishbone transfers checked through a scoreboard,
// plus sequences for timeout, IO guard, IRQ stickiness and reset during forwarding.
module tb_wb_prj_mux;
   localparam int unsigned N_PRJ       = 4;
   localparam int unsigned IO_W        = 17;
   localparam int unsigned TIMEOUT_CYC = 255;
   localparam logic [31:0] CB          = 32'h3000_0000;

   logic                  clk;
   logic                  rst;
   logic [N_PRJ-1:0]      prj_cyc_o, prj_stb_o;
   logic                  prj_we_o;
   logic [3:0]            prj_sel_o;
   logic [31:0]           prj_adr_o, prj_dat_o;
   logic [N_PRJ-1:0]      prj_ack_i;
   logic [32*N_PRJ-1:0]   prj_dat_i;
   logic [IO_W*N_PRJ-1:0] prj_io_out_i, prj_io_oeb_i;
   logic [IO_W-1:0]       io_out, io_oeb;
   logic [3*N_PRJ-1:0]    prj_irq_i;
   logic [2:0]            user_irq;

   wb_prj_mux_if wbs ();

   wb_prj_mux #(.N_PRJ(N_PRJ), .IO_W(IO_W), .CSR_BASE(CB), .TIMEOUT_CYC(TIMEOUT_CYC),
                .ERR_DATA(32'hDEAD_BEEF)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wbs(wbs),
      .prj_cyc_o(prj_cyc_o), .prj_stb_o(prj_stb_o), .prj_we_o(prj_we_o),
      .prj_sel_o(prj_sel_o), .prj_adr_o(prj_adr_o), .prj_dat_o(prj_dat_o),
      .prj_ack_i(prj_ack_i), .prj_dat_i(prj_dat_i),
      .prj_io_out_i(prj_io_out_i), .prj_io_oeb_i(prj_io_oeb_i),
      .io_out(io_out), .io_oeb(io_oeb), .prj_irq_i(prj_irq_i), .user_irq(user_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Each project answers reads with its address xor a per-project signature.
   always_comb begin
      for (int k = 0; k < N_PRJ; k++)
         prj_dat_i[32*k +: 32] = prj_adr_o ^ (32'(k) * 32'h1111_1111);
   end

   int         n_vec = 0;
   int         n_err = 0;
   bit         resp_en = 1'b1;
   bit         resp_wrong = 1'b0;
   int         resp_delay = 0;
   logic [N_PRJ-1:0] snap_stb;
   logic [31:0] snap_adr, snap_dat;
   logic        snap_we;

   // Downstream responder: acks the active project after resp_delay cycles.
   initial begin
      int cnt;
      cnt = 0;
      prj_ack_i = '0;
      snap_stb = '0; snap_adr = '0; snap_dat = '0; snap_we = 1'b0;
      forever begin
         @(posedge clk); #1;
         prj_ack_i = '0;
         if (resp_en && (prj_cyc_o != '0)) begin
            if (cnt == resp_delay) begin
               prj_ack_i = resp_wrong ? {prj_cyc_o[N_PRJ-2:0], prj_cyc_o[N_PRJ-1]} : prj_cyc_o;
               snap_stb = prj_stb_o; snap_adr = prj_adr_o; snap_dat = prj_dat_o; snap_we = prj_we_o;
               cnt = 0;
            end else begin
               cnt++;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
      $fatal(1);
   end

   typedef struct { logic [31:0] dat; bit chk; int lat; } exp_t;
   exp_t sb [$];

   typedef struct {
      bit we; logic [31:0] adr; logic [31:0] dat; bit chk; logic [31:0] exp; int lat; int dly;
   } vec_t;
   vec_t vecs [18];

   function automatic void chk_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Issue one transfer, push its expectation, pop and compare when ack returns.
   task automatic wb_xfer(input string nm, input bit we, input logic [31:0] adr,
                          input logic [31:0] dat, input bit chk, input logic [31:0] exp_dat,
                          input int exp_lat);
      exp_t e;
      int lat;
      bit got;
      logic [31:0] rd;
      e.dat = exp_dat; e.chk = chk; e.lat = exp_lat;
      sb.push_back(e);
      wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1; wbs.wbs_we_i = we;
      wbs.wbs_sel_i = 4'hF; wbs.wbs_adr_i = adr; wbs.wbs_dat_i = dat;
      lat = 0; got = 1'b0; rd = '0;
      while (!got && lat < 400) begin
         tick();
         lat++;
         if (wbs.wbs_ack_o) begin
            got = 1'b1;
            rd  = wbs.wbs_dat_o;
         end
      end
      wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0; wbs.wbs_we_i = 1'b0;
      e = sb.pop_front();
      if (!got) begin
         n_vec++; n_err++;
         $display("FAIL %s: no ack after %0d cycles, expected ack at %0d", nm, lat, e.lat);
      end else begin
         chk_val({nm, " latency"}, 32'(lat), 32'(e.lat));
         if (e.chk) chk_val({nm, " data"}, rd, e.dat);
      end
      tick();
   endtask

   initial begin
      int acks;
      wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0; wbs.wbs_we_i = 1'b0;
      wbs.wbs_sel_i = '0; wbs.wbs_adr_i = '0; wbs.wbs_dat_i = '0;
      prj_irq_i = '0;
      prj_io_out_i = {17'h1F000, 17'h00001, 17'h15555, 17'h0AAAA};
      prj_io_oeb_i = {17'h0FFFF, 17'h00000, 17'h10101, 17'h00F0F};

      vecs[0]  = '{1'b0, CB + 32'h0C, 32'h0,         1'b1, 32'h0000_0400, 1, 0};
      vecs[1]  = '{1'b0, CB + 32'h00, 32'h0,         1'b1, 32'h0,         1, 0};
      vecs[2]  = '{1'b1, CB + 32'h00, 32'h2,         1'b0, 32'h0,         1, 0};
      vecs[3]  = '{1'b0, CB + 32'h00, 32'h0,         1'b1, 32'h2,         1, 0};
      vecs[4]  = '{1'b1, CB + 32'h00, 32'h5,         1'b0, 32'h0,         1, 0};
      vecs[5]  = '{1'b0, CB + 32'h00, 32'h0,         1'b1, 32'h2,         1, 0};
      vecs[6]  = '{1'b1, CB + 32'h04, 32'h5,         1'b0, 32'h0,         1, 0};
      vecs[7]  = '{1'b0, CB + 32'h04, 32'h0,         1'b1, 32'h5,         1, 0};
      vecs[8]  = '{1'b0, CB + 32'h10, 32'h0,         1'b1, 32'h0,         1, 0};
      vecs[9]  = '{1'b1, CB + 32'h20, 32'hFFFF_FFFF, 1'b0, 32'h0,         1, 0};
      vecs[10] = '{1'b0, CB + 32'h00, 32'h0,         1'b1, 32'h2,         1, 0};
      vecs[11] = '{1'b0, 32'h3000_1000, 32'h0,       1'b1, 32'h1222_3222, 2, 0};
      vecs[12] = '{1'b0, 32'h1234_5670, 32'h0,       1'b1, 32'h3016_7452, 3, 1};
      vecs[13] = '{1'b0, 32'h0000_0004, 32'h0,       1'b1, 32'h2222_2226, 6, 4};
      vecs[14] = '{1'b1, CB + 32'h00, 32'h1,         1'b0, 32'h0,         1, 0};
      vecs[15] = '{1'b0, 32'h3000_1000, 32'h0,       1'b1, 32'h2111_0111, 2, 0};
      vecs[16] = '{1'b1, CB + 32'h00, 32'h2,         1'b0, 32'h0,         1, 0};
      vecs[17] = '{1'b0, CB + 32'h08, 32'h0,         1'b1, 32'h0,         1, 0};

      rst = 1'b1;
      repeat (3) tick();
      chk_val("reset io_oeb", 32'(io_oeb), 32'h1FFFF);
      chk_val("reset io_out", 32'(io_out), 32'h0);
      chk_val("reset user_irq", 32'(user_irq), 32'h0);
      chk_val("reset wbs_ack", 32'(wbs.wbs_ack_o), 32'h0);
      chk_val("reset wbs_dat", wbs.wbs_dat_o, 32'h0);
      chk_val("reset prj_cyc", 32'(prj_cyc_o), 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 18; i++) begin
         resp_delay = vecs[i].dly;
         wb_xfer($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, vecs[i].dat,
                 vecs[i].chk, vecs[i].exp, vecs[i].lat);
      end

      // Downstream write to project 2, ack three cycles into the cycle.
      resp_delay = 2;
      wb_xfer("fwd write", 1'b1, 32'h3000_1000, 32'h1234_5678, 1'b0, 32'h0, 4);
      chk_val("fwd write stb", 32'(snap_stb), 32'h4);
      chk_val("fwd write dat", snap_dat, 32'h1234_5678);
      chk_val("fwd write adr", snap_adr, 32'h3000_1000);
      chk_val("fwd write we", 32'(snap_we), 32'h1);
      resp_delay = 0;

      // Timeout with no ack, then with ack only on a non-selected line.
      resp_en = 1'b0;
      wb_xfer("timeout", 1'b0, 32'h3000_2000, 32'h0, 1'b1, 32'hDEAD_BEEF, TIMEOUT_CYC + 2);
      wb_xfer("status after timeout", 1'b0, CB + 32'h0C, 32'h0, 1'b1, 32'h0000_0401, 1);
      wb_xfer("status cleared", 1'b0, CB + 32'h0C, 32'h0, 1'b1, 32'h0000_0400, 1);
      resp_en = 1'b1; resp_wrong = 1'b1;
      wb_xfer("wrong-line ack", 1'b0, 32'h3000_2004, 32'h0, 1'b1, 32'hDEAD_BEEF, TIMEOUT_CYC + 2);
      resp_wrong = 1'b0;
      wb_xfer("status wrong-line", 1'b0, CB + 32'h0C, 32'h0, 1'b1, 32'h0000_0401, 1);

      // IO guard cycle on select change, none for a rewrite of the same value.
      wb_xfer("sel0", 1'b1, CB, 32'h0, 1'b0, 32'h0, 1);
      repeat (3) tick();
      chk_val("io prj0 out", 32'(io_out), 32'h0AAAA);
      chk_val("io prj0 oeb", 32'(io_oeb), 32'h00F0F);
      wb_xfer("sel1", 1'b1, CB, 32'h1, 1'b0, 32'h0, 1);
      chk_val("guard oeb", 32'(io_oeb), 32'h1FFFF);
      chk_val("guard out", 32'(io_out), 32'h0);
      tick();
      chk_val("io prj1 out", 32'(io_out), 32'h15555);
      chk_val("io prj1 oeb", 32'(io_oeb), 32'h10101);
      wb_xfer("sel1 again", 1'b1, CB, 32'h1, 1'b0, 32'h0, 1);
      chk_val("no guard oeb", 32'(io_oeb), 32'h10101);
      tick();
      chk_val("no guard out", 32'(io_out), 32'h15555);

      // Sticky pending, masking, W1C and set-wins collision.
      wb_xfer("mask 010", 1'b1, CB + 32'h04, 32'h2, 1'b0, 32'h0, 1);
      prj_irq_i[4] = 1'b1;
      tick();
      prj_irq_i[4] = 1'b0;
      repeat (3) tick();
      chk_val("irq rise", 32'(user_irq), 32'h2);
      repeat (5) tick();
      chk_val("irq sticky", 32'(user_irq), 32'h2);
      wb_xfer("pend w1c", 1'b1, CB + 32'h08, 32'h2, 1'b0, 32'h0, 1);
      repeat (2) tick();
      chk_val("irq cleared", 32'(user_irq), 32'h0);
      prj_irq_i[4] = 1'b1;
      fork
         wb_xfer("pend w1c collide", 1'b1, CB + 32'h08, 32'h2, 1'b0, 32'h0, 1);
         begin @(posedge clk); #1; prj_irq_i[4] = 1'b0; end
      join
      repeat (2) tick();
      chk_val("irq set wins", 32'(user_irq), 32'h2);
      wb_xfer("pend after collide", 1'b0, CB + 32'h08, 32'h0, 1'b1, 32'h2, 1);
      wb_xfer("sel0 keep pend", 1'b1, CB, 32'h0, 1'b0, 32'h0, 1);
      prj_irq_i[0] = 1'b1;
      tick();
      prj_irq_i[0] = 1'b0;
      repeat (3) tick();
      chk_val("irq masked bit0", 32'(user_irq), 32'h2);
      wb_xfer("pend across sel", 1'b0, CB + 32'h08, 32'h0, 1'b1, 32'h3, 1);

      // Reset while a downstream cycle is outstanding.
      resp_en = 1'b0;
      wb_xfer("sel3", 1'b1, CB, 32'h3, 1'b0, 32'h0, 1);
      wb_xfer("mask 111", 1'b1, CB + 32'h04, 32'h7, 1'b0, 32'h0, 1);
      wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1; wbs.wbs_we_i = 1'b0;
      wbs.wbs_adr_i = 32'h3000_3000;
      tick();
      chk_val("fwd onehot prj3", 32'(prj_cyc_o), 32'h8);
      tick();
      rst = 1'b1;
      tick();
      chk_val("rst fwd prj_cyc", 32'(prj_cyc_o), 32'h0);
      chk_val("rst fwd ack", 32'(wbs.wbs_ack_o), 32'h0);
      rst = 1'b0;
      wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0;
      acks = 0;
      repeat (10) begin
         tick();
         if (wbs.wbs_ack_o) acks++;
      end
      chk_val("no ack after reset", 32'(acks), 32'h0);
      resp_en = 1'b1;
      wb_xfer("sel after rst", 1'b0, CB + 32'h00, 32'h0, 1'b1, 32'h0, 1);
      wb_xfer("mask after rst", 1'b0, CB + 32'h04, 32'h0, 1'b1, 32'h0, 1);
      wb_xfer("pend after rst", 1'b0, CB + 32'h08, 32'h0, 1'b1, 32'h0, 1);
      wb_xfer("status after rst", 1'b0, CB + 32'h0C, 32'h0, 1'b1, 32'h0000_0400, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
